// File: rtl/nn_smoothgrad_sched_if.sv
// Bundle of the run-control inputs and schedule outputs of nn_smoothgrad_sched.
// master = controller/testbench side, slave = scheduler side.
interface nn_smoothgrad_sched_if #(
    parameter int NBANK   = 4,
    parameter int WIN_W   = 8,
    parameter int EPOCH_W = 16
);
    logic               start;
    logic               stop;
    logic [WIN_W-1:0]   window;
    logic [EPOCH_W-1:0] epochs;
    logic [7:0]         res_start;
    logic [7:0]         res_min;
    logic [7:0]         res_step;
    logic [7:0]         anneal_period;

    logic               param_init;
    logic [NBANK-1:0]   en;
    logic               train_flag;
    logic [7:0]         resistance;
    logic [EPOCH_W-1:0] epoch_cnt;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, window, epochs, res_start, res_min, res_step, anneal_period,
        input  param_init, en, train_flag, resistance, epoch_cnt, busy, done
    );

    modport slave (
        input  start, stop, window, epochs, res_start, res_min, res_step, anneal_period,
        output param_init, en, train_flag, resistance, epoch_cnt, busy, done
    );
endinterface

// File: rtl/nn_smoothgrad_sched.sv
// Training-run sequencer: forward window, then one update window per bank, per epoch.
// Define NN_SMOOTHGRAD_ANNEAL_EN to compile in the resistance anneal schedule.
module nn_smoothgrad_sched #(
    parameter int NBANK   = 4,
    parameter int WIN_W   = 8,
    parameter int EPOCH_W = 16
) (
    input  logic clk,
    input  logic init,
    nn_smoothgrad_sched_if.slave bus
);
    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FWD, S_UPD, S_NEXT, S_FIN
    } state_t;

    state_t             state_reg, state_next;
    logic [WIN_W-1:0]   window_reg;
    logic [EPOCH_W-1:0] epochs_reg;
    logic [EPOCH_W-1:0] epoch_cnt_reg;
    logic [WIN_W-1:0]   win_cnt_reg;
    logic [BANK_W-1:0]  bank_reg;
    logic [7:0]         res_reg;

    logic [WIN_W-1:0]   win_eff;
    logic               win_last;
    logic               bank_last;
    logic [EPOCH_W-1:0] epoch_inc;
    logic               launch;

    // A zero-length window still gives every phase one cycle.
    assign win_eff   = (window_reg == '0) ? WIN_W'(1) : window_reg;
    assign win_last  = (win_cnt_reg == win_eff - WIN_W'(1));
    assign bank_last = (bank_reg == BANK_W'(NBANK - 1));
    assign epoch_inc = epoch_cnt_reg + EPOCH_W'(1);
    assign launch    = bus.start && !bus.stop;

`ifdef NN_SMOOTHGRAD_ANNEAL_EN
    logic [7:0] res_min_reg, res_step_reg, period_reg, anneal_cnt_reg;
    logic [7:0] res_annealed;

    // Clamp at the floor without ever forming res - step below zero.
    always_comb begin
        res_annealed = res_reg;
        if (res_reg > res_min_reg) begin
            if ((res_reg - res_min_reg) > res_step_reg)
                res_annealed = res_reg - res_step_reg;
            else
                res_annealed = res_min_reg;
        end
    end
`else
    logic unused_sched;
    assign unused_sched = ^{bus.res_min, bus.res_step, bus.anneal_period};
`endif

    // State register
    always_ff @(posedge clk or posedge init) begin
        if (init)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic; stop overrides every other transition once running
    always_comb begin
        state_next = state_reg;
        if (state_reg != S_IDLE && bus.stop) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (launch) state_next = S_LOAD;
                S_LOAD: state_next = (epochs_reg == '0) ? S_FIN : S_FWD;
                S_FWD:  if (win_last) state_next = S_UPD;
                S_UPD:  if (win_last && bank_last) state_next = S_NEXT;
                S_NEXT: state_next = (epoch_inc == epochs_reg) ? S_FIN : S_FWD;
                S_FIN:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Run configuration, counters and the resistance schedule
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            window_reg    <= '0;
            epochs_reg    <= '0;
            epoch_cnt_reg <= '0;
            win_cnt_reg   <= '0;
            bank_reg      <= '0;
            res_reg       <= '0;
`ifdef NN_SMOOTHGRAD_ANNEAL_EN
            res_min_reg    <= '0;
            res_step_reg   <= '0;
            period_reg     <= '0;
            anneal_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (launch) begin
                        window_reg    <= bus.window;
                        epochs_reg    <= bus.epochs;
                        epoch_cnt_reg <= '0;
                        win_cnt_reg   <= '0;
                        bank_reg      <= '0;
                        res_reg       <= bus.res_start;
`ifdef NN_SMOOTHGRAD_ANNEAL_EN
                        res_min_reg    <= bus.res_min;
                        res_step_reg   <= bus.res_step;
                        period_reg     <= bus.anneal_period;
                        anneal_cnt_reg <= '0;
`endif
                    end
                end
                S_FWD: begin
                    if (!bus.stop) begin
                        if (win_last) begin
                            win_cnt_reg <= '0;
                            bank_reg    <= '0;
                        end else begin
                            win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                        end
                    end
                end
                S_UPD: begin
                    if (!bus.stop) begin
                        if (win_last) begin
                            win_cnt_reg <= '0;
                            if (!bank_last)
                                bank_reg <= bank_reg + BANK_W'(1);
                        end else begin
                            win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                        end
                    end
                end
                S_NEXT: begin
                    if (!bus.stop) begin
                        epoch_cnt_reg <= epoch_inc;
`ifdef NN_SMOOTHGRAD_ANNEAL_EN
                        if (period_reg != '0) begin
                            if (anneal_cnt_reg == period_reg - 8'd1) begin
                                anneal_cnt_reg <= '0;
                                res_reg        <= res_annealed;
                            end else begin
                                anneal_cnt_reg <= anneal_cnt_reg + 8'd1;
                            end
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from state (and bank index) only
    logic             param_init_d, train_flag_d, busy_d, done_d;
    logic [NBANK-1:0] en_d;

    always_comb begin
        param_init_d = 1'b0;
        train_flag_d = 1'b0;
        busy_d       = (state_reg != S_IDLE);
        done_d       = 1'b0;
        case (state_reg)
            S_LOAD:  param_init_d = 1'b1;
            S_UPD:   train_flag_d = 1'b1;
            S_FIN:   done_d       = 1'b1;
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NBANK; gi++) begin : g_en
            assign en_d[gi] = (state_reg == S_UPD) && (bank_reg == BANK_W'(gi));
        end
    endgenerate

    assign bus.param_init = param_init_d;
    assign bus.en         = en_d;
    assign bus.train_flag = train_flag_d;
    assign bus.busy       = busy_d;
    assign bus.done       = done_d;
    assign bus.resistance = res_reg;
    assign bus.epoch_cnt  = epoch_cnt_reg;
endmodule

// File: tb/tb_nn_smoothgrad_sched.sv
// Randomized bench for nn_smoothgrad_sched: expected per-cycle output traces are built
// from the run rules (phase lengths, anneal arithmetic) and compared cycle by cycle.
module tb_nn_smoothgrad_sched;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic init = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    nn_smoothgrad_sched_if #(.NBANK(NB), .WIN_W(8), .EPOCH_W(16)) bus ();

    nn_smoothgrad_sched #(.NBANK(NB), .WIN_W(8), .EPOCH_W(16)) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    typedef struct packed {
        logic        param;
        logic [NB-1:0] en;
        logic        tf;
        logic        busy;
        logic        done;
        logic [7:0]  res;
        logic [15:0] ep;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic chk_idle_ctrl(input string tag);
        chk({tag, ".busy"},  64'(bus.busy), 64'd0);
        chk({tag, ".en"},    64'(bus.en), 64'd0);
        chk({tag, ".tf"},    64'(bus.train_flag), 64'd0);
        chk({tag, ".done"},  64'(bus.done), 64'd0);
        chk({tag, ".param"}, 64'(bus.param_init), 64'd0);
    endtask

    // Expected trace: LOAD, epochs of (W fwd, NB*W upd, 1 next), FIN, one IDLE cycle.
    task automatic build(input int w, input int e, input int rs, input int rmin,
                         input int rstep, input int per);
        int weff, r, ec, acnt;
        exp_t x;
        weff = (w == 0) ? 1 : w;
        r = rs; ec = 0; acnt = 0;
        q.delete();
        x = '{param:1, en:0, tf:0, busy:1, done:0, res:8'(r), ep:16'(ec)};
        q.push_back(x);
        for (int ep = 0; ep < e; ep++) begin
            for (int c = 0; c < weff; c++) begin
                x = '{param:0, en:0, tf:0, busy:1, done:0, res:8'(r), ep:16'(ec)};
                q.push_back(x);
            end
            for (int b = 0; b < NB; b++)
                for (int c = 0; c < weff; c++) begin
                    x = '{param:0, en:NB'(1 << b), tf:1, busy:1, done:0, res:8'(r), ep:16'(ec)};
                    q.push_back(x);
                end
            x = '{param:0, en:0, tf:0, busy:1, done:0, res:8'(r), ep:16'(ec)};
            q.push_back(x);
            ec++;
`ifdef NN_SMOOTHGRAD_ANNEAL_EN
            if (per != 0) begin
                acnt++;
                if (acnt >= per) begin
                    acnt = 0;
                    if (r > rmin) r = (r - rstep < rmin) ? rmin : r - rstep;
                end
            end
`else
            acnt = acnt + (per & 0) + (rmin & 0) + (rstep & 0);
`endif
        end
        x = '{param:0, en:0, tf:0, busy:1, done:1, res:8'(r), ep:16'(ec)};
        q.push_back(x);
        x = '{param:0, en:0, tf:0, busy:0, done:0, res:8'(r), ep:16'(ec)};
        q.push_back(x);
    endtask

    task automatic run_case(input int w, input int e, input int rs, input int rmin,
                            input int rstep, input int per, input int stop_at);
        int n;
        build(w, e, rs, rmin, rstep, per);
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b0;
        bus.window = 8'(w); bus.epochs = 16'(e);
        bus.res_start = 8'(rs); bus.res_min = 8'(rmin);
        bus.res_step = 8'(rstep); bus.anneal_period = 8'(per);
        n = 0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                // scramble the config inputs: the latched copy must be used
                bus.start = 1'b0;
                bus.window = 8'($urandom); bus.epochs = 16'($urandom_range(0, 9));
                bus.res_start = 8'($urandom); bus.res_min = 8'($urandom);
                bus.res_step = 8'($urandom); bus.anneal_period = 8'($urandom);
            end
            chk("param", 64'(bus.param_init), 64'(q[i].param));
            chk("en",    64'(bus.en),         64'(q[i].en));
            chk("tf",    64'(bus.train_flag), 64'(q[i].tf));
            chk("busy",  64'(bus.busy),       64'(q[i].busy));
            chk("done",  64'(bus.done),       64'(q[i].done));
            chk("res",   64'(bus.resistance), 64'(q[i].res));
            chk("epoch", 64'(bus.epoch_cnt),  64'(q[i].ep));
            n++;
            if (i == stop_at) begin
                bus.stop = 1'b1;
                @(negedge clk);
                bus.stop = 1'b0;
                chk_idle_ctrl("abort");
                @(negedge clk);
                chk_idle_ctrl("abort+1");
                break;
            end
        end
        $display("run w=%0d e=%0d rs=%0d min=%0d step=%0d per=%0d stop_at=%0d cycles=%0d bad=%0d",
                 w, e, rs, rmin, rstep, per, stop_at, n, bad);
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.window = '0; bus.epochs = '0;
        bus.res_start = '0; bus.res_min = '0; bus.res_step = '0; bus.anneal_period = '0;
        repeat (3) @(negedge clk);
        chk("rst.res",   64'(bus.resistance), 64'd0);
        chk("rst.epoch", 64'(bus.epoch_cnt),  64'd0);
        chk_idle_ctrl("rst");
        init = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_ctrl("post_rst");

        run_case(4, 2, 50, 0, 0, 0, -1);               // basic: DONE 44 cycles after start
        run_case(4, 5, 10, 2, 3, 1, -1);               // anneal 7,4,2,2,2
        run_case(3, 4, 200, 100, 40, 2, -1);           // anneal every second epoch
        run_case(2, 0, 33, 0, 0, 0, -1);               // zero epochs
        run_case(0, 3, 9, 1, 1, 1, -1);                // zero window
        run_case(4, 2, 10, 2, 3, 1, 1 + 4 + 2 * 4);    // stop while en=0100

        for (int k = 0; k < 14; k++) begin
            int w, e, sa, len;
            w = $urandom_range(0, 5);
            e = $urandom_range(0, 4);
            len = 3 + e * ((w == 0 ? 1 : w) * (NB + 1) + 1);
            sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 3) : -1;
            run_case(w, e, $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 3), sa);
        end

        // start and stop together in IDLE: nothing happens
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b1; bus.epochs = 16'd2; bus.window = 8'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        chk_idle_ctrl("conflict");
        @(negedge clk);
        chk_idle_ctrl("conflict+1");
        $display("run conflict start+stop bad=%0d", bad);

        // asynchronous reset in the middle of UPD
        @(negedge clk);
        bus.start = 1'b1; bus.window = 8'd3; bus.epochs = 16'd2; bus.res_start = 8'd77;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_init.en", 64'(bus.en), 64'h1);
        #2 init = 1'b1;
        #1;
        chk("init.res",   64'(bus.resistance), 64'd0);
        chk("init.epoch", 64'(bus.epoch_cnt),  64'd0);
        chk_idle_ctrl("init");
        @(negedge clk);
        init = 1'b0;
        repeat (5) @(negedge clk);
        chk_idle_ctrl("init_rel");
        chk("init_rel.res", 64'(bus.resistance), 64'd0);
        $display("run reset mid-UPD bad=%0d", bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nn_smoothgrad_sched.md
NN_SMOOTHGRAD_SCHED -- requirements
Module: nn_smoothgrad_sched

Interface
REQ-001 Parameter NBANK, default 4: number of gradient-update parameter banks, sequenced one at a time.
REQ-002 Parameter WIN_W, default 8: width of the phase-window length.
REQ-003 Parameter EPOCH_W, default 16: width of the epoch count.
REQ-004 CLK  in  1  sole clock; all logic on the rising edge.
REQ-005 INIT  in  1  reset, asynchronous, active-high.
REQ-006 START  in  1  begin a training run; sampled in IDLE only.
REQ-007 STOP  in  1  abort the run.
REQ-008 WINDOW  in  WIN_W  cycles per phase.
REQ-009 EPOCHS  in  EPOCH_W  epochs per run.
REQ-010 RES_START, RES_MIN, RES_STEP, ANNEAL_PERIOD  in  8 each  resistance schedule: initial value, floor, step, and epochs per step.
REQ-011 PARAM_INIT  out  1  one-cycle pulse that loads the bank initial values.
REQ-012 EN  out  NBANK  one-hot update enable per bank.
REQ-013 TRAIN_FLAG  out  1  training-phase flag driven to all banks.
REQ-014 RESISTANCE  out  8  update resistance broadcast to all banks.
REQ-015 EPOCH_CNT  out  EPOCH_W  number of completed epochs.
REQ-016 BUSY  out  1  high in every state except IDLE.
REQ-017 DONE  out  1  one-cycle completion pulse.

Function
REQ-018 The block SHALL be a registered FSM with states IDLE, LOAD, FWD, UPD, NEXT and FIN; all outputs SHALL be registered or decoded from state only.
REQ-019 IDLE: START=1 and STOP=0 at an edge SHALL move to LOAD, latch WINDOW, EPOCHS and the four schedule inputs, and clear EPOCH_CNT.
REQ-020 In IDLE, START=1 together with STOP=1 SHALL leave the FSM in IDLE.
REQ-021 LOAD SHALL last one cycle with PARAM_INIT=1 and RESISTANCE=RES_START; it SHALL go to FIN if EPOCHS==0, else to FWD.
REQ-022 FWD SHALL last W cycles with EN=0 and TRAIN_FLAG=0, then go to UPD with bank index 0; W=WINDOW, except WINDOW==0 SHALL be treated as W=1.
REQ-023 UPD SHALL hold EN=onehot(bank) and TRAIN_FLAG=1 for W cycles per bank.
REQ-024 After W cycles in UPD, bank<NBANK-1 SHALL increment bank with the window counter cleared, and bank==NBANK-1 SHALL go to NEXT; EN SHALL never have more than one bit set.
REQ-025 NEXT SHALL last one cycle with EN=0: EPOCH_CNT+1 is written, the anneal step of REQ-028 is applied, then FIN if the new count equals EPOCHS, else FWD.
REQ-026 One epoch SHALL take exactly W + NBANK*W + 1 cycles.
REQ-027 FIN SHALL last one cycle with DONE=1, then go to IDLE; EPOCH_CNT and RESISTANCE SHALL hold in IDLE until the next LOAD.
REQ-028 Anneal step: an epoch counter counts NEXT visits. When it reaches ANNEAL_PERIOD-1 it SHALL clear, and RESISTANCE SHALL become max(RESISTANCE-RES_STEP, RES_MIN), computed without 8-bit underflow. RESISTANCE SHALL never change if it is already at or below RES_MIN, or if ANNEAL_PERIOD==0.
REQ-029 STOP=1 in any non-IDLE state SHALL go to IDLE at the next edge with EN=0, TRAIN_FLAG=0 and no DONE pulse; STOP SHALL take priority over every other transition.
REQ-030 Changes to the latched inputs during a run SHALL have no effect until the next START.

Reset
REQ-031 INIT=1 SHALL immediately force state IDLE and PARAM_INIT=0, EN=0, TRAIN_FLAG=0, BUSY=0, DONE=0, RESISTANCE=0, EPOCH_CNT=0, and clear all internal counters, including mid-run.
REQ-032 Release of INIT SHALL not start a run; a new START is required.

Configuration
REQ-033 Macro NN_SMOOTHGRAD_ANNEAL_EN defined: the anneal logic of REQ-028 SHALL be compiled in.
REQ-034 Macro NN_SMOOTHGRAD_ANNEAL_EN undefined: the anneal logic SHALL be absent, RESISTANCE SHALL stay at RES_START for the whole run, and RES_MIN, RES_STEP and ANNEAL_PERIOD SHALL be ignored.

Verification
REQ-035 Basic run: NBANK=4, WINDOW=4, EPOCHS=2, START at edge k -> PARAM_INIT high in cycle k+1, DONE high in cycle k+44, EPOCH_CNT=2, and each EN bit high for 4 cycles per epoch.
REQ-036 Anneal (macro defined): RES_START=10, RES_STEP=3, RES_MIN=2, ANNEAL_PERIOD=1, EPOCHS=5 -> RESISTANCE after each NEXT reads 7, 4, 2, 2, 2; with the macro undefined it stays 10.
REQ-037 Abort: STOP pulsed while EN=4'b0100 -> next cycle IDLE with EN=0, BUSY=0 and no DONE pulse.
REQ-038 Edge inputs: EPOCHS=0 -> LOAD then FIN, with DONE at edge k+2 and EN never set; WINDOW=0 -> every phase lasts 1 cycle.
REQ-039 Reset: INIT asserted mid-UPD -> all outputs 0 asynchronously; after INIT release with START=0 the block remains in IDLE.
REQ-040 Conflict: START=1 and STOP=1 together in IDLE -> BUSY stays 0.
